// File: rtl/llc_req_merge_q_pkg.sv
// rtl/llc_req_merge_q_pkg.sv - request packet layout and message codes for the LLC request merger
package llc_req_merge_q_pkg;

    localparam int LLC_MSG_W   = 5;
    localparam int LLC_HPROT_W = 2;
    localparam int LLC_ADDR_W  = 28;
    localparam int LLC_LINE_W  = 128;
    localparam int LLC_ID_W    = 6;
    localparam int LLC_WO_W    = 3;
    localparam int LLC_P_W     = LLC_MSG_W + LLC_HPROT_W + LLC_ADDR_W + LLC_LINE_W
                               + LLC_ID_W + 2 * LLC_WO_W;

    localparam logic [LLC_MSG_W-1:0] REQ_GETS      = 5'd0;
    localparam logic [LLC_MSG_W-1:0] REQ_GETM      = 5'd1;
    localparam logic [LLC_MSG_W-1:0] REQ_PUTS      = 5'd2;
    localparam logic [LLC_MSG_W-1:0] REQ_PUTM      = 5'd3;
    localparam logic [LLC_MSG_W-1:0] REQ_DMA_READ  = 5'd12;
    localparam logic [LLC_MSG_W-1:0] REQ_DMA_WRITE = 5'd13;

    // hprot[0] marks that a DMA write burst continues with the next packet
    typedef struct packed {
        logic [LLC_MSG_W-1:0]   msg;
        logic [LLC_HPROT_W-1:0] hprot;
        logic [LLC_ADDR_W-1:0]  addr;
        logic [LLC_LINE_W-1:0]  line;
        logic [LLC_ID_W-1:0]    req_id;
        logic [LLC_WO_W-1:0]    word_offset;
        logic [LLC_WO_W-1:0]    valid_words;
    } llc_req_pkt_t;

endpackage

// File: rtl/llc_req_fifo.sv
// rtl/llc_req_fifo.sv - single-channel synchronous request FIFO, registered storage
module llc_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    // Full depends on the stored count only, so a pop never frees a slot for the same cycle
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/llc_req_merge_q.sv
// rtl/llc_req_merge_q.sv - N-channel buffered LLC request merger with round-robin and DMA-write burst lock
module llc_req_merge_q
    import llc_req_merge_q_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DEPTH   = 4,
    parameter int MSG_W   = LLC_MSG_W,
    parameter int HPROT_W = LLC_HPROT_W,
    parameter int ADDR_W  = LLC_ADDR_W,
    parameter int LINE_W  = LLC_LINE_W,
    parameter int ID_W    = LLC_ID_W,
    parameter int WO_W    = LLC_WO_W,
    parameter logic [MSG_W-1:0] DMA_WR_MSG = REQ_DMA_WRITE,
    localparam int P_W  = MSG_W + HPROT_W + ADDR_W + LINE_W + ID_W + 2 * WO_W,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     in_valid,
    output logic [N_CH-1:0]     in_ready,
    input  logic [N_CH*P_W-1:0] in_pkt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_W-1:0]      out_pkt,
    output logic [CH_W-1:0]     out_ch,
    output logic [N_CH-1:0]     q_empty,
    output logic                locked
);

    logic [N_CH-1:0]  full_w;
    logic [N_CH-1:0]  empty_w;
    logic [N_CH-1:0]  push_w;
    logic [N_CH-1:0]  pop_w;
    logic [P_W-1:0]   dout_w [N_CH];

    logic [CH_W-1:0]  rr_q, rr_d;
    logic [CH_W-1:0]  lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]  grant_q, grant_d;
    logic             lock_q, lock_d;
    logic             hold_q, hold_d;

    logic [N_CH-1:0]  elig;
    logic [CH_W:0]    idx;
    logic             found;
    logic [CH_W-1:0]  gnt_rr;
    logic [CH_W-1:0]  gnt;
    logic [P_W-1:0]   gnt_pkt;
    logic [MSG_W-1:0] gnt_msg;
    logic             gnt_cont;
    logic             hs;

    function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] c);
        if (c == CH_W'(N_CH - 1)) begin
            return '0;
        end
        return c + CH_W'(1);
    endfunction

    assign in_ready = ~full_w;
    assign push_w   = in_valid & ~full_w;
    assign q_empty  = empty_w;
    assign locked   = lock_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        llc_req_fifo #(
            .DEPTH (DEPTH),
            .W     (P_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_w[k]),
            .pop   (pop_w[k]),
            .din   (in_pkt[k*P_W +: P_W]),
            .dout  (dout_w[k]),
            .full  (full_w[k]),
            .empty (empty_w[k])
        );
        assign pop_w[k] = hs && (gnt == CH_W'(k));
    end

    // Inside a burst only the locked channel may be offered, even if it runs dry
    always_comb begin
        elig = ~empty_w;
        if (lock_q) begin
            elig = '0;
            elig[lock_ch_q] = ~empty_w[lock_ch_q];
        end
    end

    always_comb begin
        gnt_rr = rr_q;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = {1'b0, rr_q} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(N_CH)) begin
                idx = idx - (CH_W+1)'(N_CH);
            end
            if (!found && elig[idx[CH_W-1:0]]) begin
                found  = 1'b1;
                gnt_rr = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        gnt       = hold_q ? grant_q : gnt_rr;
        out_valid = hold_q | (|elig);
        gnt_pkt   = dout_w[gnt];
        out_pkt   = out_valid ? gnt_pkt : '0;
        out_ch    = out_valid ? gnt : '0;
        hs        = out_valid && out_ready;
        gnt_msg   = gnt_pkt[P_W-1 -: MSG_W];
        gnt_cont  = gnt_pkt[P_W-MSG_W-HPROT_W];

        rr_d      = rr_q;
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        hold_d    = hold_q;
        grant_d   = grant_q;

        if (hs) begin
            hold_d = 1'b0;
            if (lock_q) begin
                if (!gnt_cont) begin
                    lock_d = 1'b0;
                    rr_d   = ch_next(lock_ch_q);
                end
            end else if (gnt_msg == DMA_WR_MSG && gnt_cont) begin
                lock_d    = 1'b1;
                lock_ch_d = gnt;
            end else begin
                rr_d = ch_next(gnt);
            end
        end else if (out_valid) begin
            // Freeze the offer so a newly filled channel cannot displace it
            hold_d  = 1'b1;
            grant_d = gnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
            hold_q    <= 1'b0;
            grant_q   <= '0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
        end
    end

endmodule
